// File: rtl/instr_prefetch_aligner_pkg.sv
// Shared types and helpers for the instruction prefetch/aligner slice.
package instr_prefetch_aligner_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
    } fetch_entry_t;

    // Any opcode other than 2'b11 marks a 16-bit compressed instruction.
    function automatic logic is_rvc(input logic [1:0] opcode);
        return opcode != 2'b11;
    endfunction

endpackage

// File: rtl/instr_prefetch_aligner_fetch_fifo.sv
// Word queue between the instruction bus and the aligner; exposes head and head+1.
module instr_prefetch_aligner_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [WIDTH-1:0]               rdata0_o,
    output logic [WIDTH-1:0]               rdata1_o,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Flush wins over any push/pop in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata0_o    = mem_q[rd_ptr_q];
    assign rdata1_o    = mem_q[rd_ptr_q + PTR_W'(1)];
    assign occupancy_o = occ_q;

    // The request credit scheme must never let a response hit a full queue.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_i && !flush_i) |-> ((occ_q < OCC_W'(DEPTH)) || pop_i));

endmodule

// File: rtl/instr_prefetch_aligner.sv
// Instruction prefetch queue with halfword aligner: bus words in, whole RV32/RVC instructions out.
module instr_prefetch_aligner
    import instr_prefetch_aligner_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        MAX_OUT  = 2,
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_addr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic              instr_compressed_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  disc_q, disc_d;
    logic              req_q, req_d;

    logic [CNT_W-1:0]  occ, occ_nxt;
    fetch_entry_t      push_entry, head, nxt;
    logic              gnt, drop, push, pop, hs;
    logic              valid_c, cmp_c, need_two_c, pop_on_hs_c;
    logic [31:0]       instr_c;
    logic              unused_nxt_hi;

    assign push_entry.word = mem_rdata_i;

    instr_prefetch_aligner_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .wdata_i     (push_entry),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .rdata0_o    (head),
        .rdata1_o    (nxt),
        .occupancy_o (occ)
    );

    assign unused_nxt_hi = ^nxt.word[31:16];

    // Halfword aligner: pc[1] selects which half of the head word starts the instruction.
    always_comb begin
        instr_c     = head.word;
        cmp_c       = 1'b0;
        need_two_c  = 1'b0;
        pop_on_hs_c = 1'b1;
        if (!pc_q[1]) begin
            if (is_rvc(head.word[1:0])) begin
                instr_c     = {16'h0000, head.word[15:0]};
                cmp_c       = 1'b1;
                pop_on_hs_c = 1'b0;
            end
        end else begin
            if (is_rvc(head.word[17:16])) begin
                instr_c = {16'h0000, head.word[31:16]};
                cmp_c   = 1'b1;
            end else begin
                instr_c    = {nxt.word[15:0], head.word[31:16]};
                need_two_c = 1'b1;
            end
        end
        valid_c = !flush_i && (need_two_c ? (occ >= CNT_W'(2)) : (occ != '0));
    end

    assign gnt  = req_q && mem_gnt_i;
    assign drop = mem_rvalid_i && (disc_q != '0);
    assign push = mem_rvalid_i && !drop && !flush_i;
    assign hs   = valid_c && instr_ready_i;
    assign pop  = hs && pop_on_hs_c;

    // Next-state: outstanding tracking, discard credits, fetch/pc redirect and request credit.
    always_comb begin
        out_d        = out_q + CNT_W'(gnt) - CNT_W'(mem_rvalid_i);
        disc_d       = disc_q - CNT_W'(drop);
        fetch_addr_d = gnt ? fetch_addr_q + ADDR_W'(4) : fetch_addr_q;
        pc_d         = pc_q;
        occ_nxt      = occ + CNT_W'(push) - CNT_W'(pop);
        if (hs) begin
            pc_d = pc_q + (cmp_c ? ADDR_W'(2) : ADDR_W'(4));
        end
        if (flush_i) begin
            disc_d       = out_d;
            fetch_addr_d = {flush_addr_i[ADDR_W-1:2], 2'b00};
            pc_d         = flush_addr_i;
            occ_nxt      = '0;
        end
        req_d = ((SUM_W'(occ_nxt) + SUM_W'(out_d)) < SUM_W'(DEPTH)) &&
                (out_d < CNT_W'(MAX_OUT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
            pc_q         <= RESET_PC;
            out_q        <= '0;
            disc_q       <= '0;
            req_q        <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            pc_q         <= pc_d;
            out_q        <= out_d;
            disc_q       <= disc_d;
            req_q        <= req_d;
        end
    end

    assign mem_req_o          = req_q;
    assign mem_addr_o         = fetch_addr_q;
    assign instr_valid_o      = valid_c;
    assign instr_o            = valid_c ? instr_c : INST_NOP;
    assign instr_compressed_o = valid_c && cmp_c;
    assign pc_o               = pc_q;
    assign pc_next_o          = pc_q + (instr_compressed_o ? ADDR_W'(2) : ADDR_W'(4));

    // Redirect targets must be halfword aligned.
    assert property (@(posedge clk_i) disable iff (!rst_ni) flush_i |-> !flush_addr_i[0]);

endmodule
